// File: rtl/uart.sv
// uart: 8N1 full-duplex UART with synchronized receiver and registered transmitter
module uart #(
  parameter int baud_rate    = 9600,
  parameter int sys_clk_freq = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam int DIV = sys_clk_freq / baud_rate;
  localparam int TW  = $clog2(DIV + 1);
  localparam logic [TW-1:0] BIT_T  = TW'(DIV);
  localparam logic [TW-1:0] HALF_T = TW'(DIV / 2);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic [1:0]    sync_q, sync_d;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [TW-1:0] rx_timer_q, rx_timer_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          received_q, received_d;
  logic          recv_error_q, recv_error_d;
  logic [1:0]    tx_state_q, tx_state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          rxs, rx_exp, tx_exp, tx_last;

  assign rxs     = sync_q[1];
  assign rx_exp  = rx_timer_q == ONE_T;
  assign tx_exp  = tx_timer_q == ONE_T;
  assign tx_last = tx_idx_q == 3'd7;
  assign sync_d  = {sync_q[0], rx};

  // Receiver: start-bit qualification at half a bit, then mid-bit sampling of data and stop
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_timer_d   = rx_timer_q - ONE_T;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rxs) begin
        rx_state_d = RX_START;
        rx_timer_d = HALF_T;
      end
      RX_START: if (rx_exp) begin
        rx_state_d = rxs ? RX_IDLE : RX_DATA;
        rx_timer_d = BIT_T;
        rx_idx_d   = 3'd0;
      end
      RX_DATA: if (rx_exp) begin
        rx_shift_d = {rxs, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
        rx_timer_d = BIT_T;
        rx_state_d = (rx_idx_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_exp) begin
        rx_state_d   = rxs ? RX_IDLE : RX_WAIT_HIGH;
        rx_byte_d    = rxs ? rx_shift_q : rx_byte_q;
        received_d   = rxs;
        recv_error_d = !rxs;
      end
      RX_WAIT_HIGH: if (rxs) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmitter: each of start, eight data bits and stop holds tx for one full bit period
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q - ONE_T;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: if (transmit) begin
        tx_state_d = TX_START;
        tx_shift_d = tx_byte;
        tx_timer_d = BIT_T;
        tx_d       = 1'b0;
      end
      TX_START: if (tx_exp) begin
        tx_state_d = TX_DATA;
        tx_timer_d = BIT_T;
        tx_idx_d   = 3'd0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_exp) begin
        tx_state_d = tx_last ? TX_STOP : TX_DATA;
        tx_timer_d = BIT_T;
        tx_idx_d   = tx_idx_q + 3'd1;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_d       = tx_last ? 1'b1 : tx_shift_q[1];
      end
      default: if (tx_exp) begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts both directions and forces the line idle high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      rx_state_q   <= RX_IDLE;
      rx_timer_q   <= '0;
      rx_idx_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_byte_q    <= 8'h00;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_timer_q   <= '0;
      tx_idx_q     <= 3'd0;
      tx_shift_q   <= 8'h00;
      tx_q         <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      rx_state_q   <= rx_state_d;
      rx_timer_q   <= rx_timer_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
      tx_state_q   <= tx_state_d;
      tx_timer_q   <= tx_timer_d;
      tx_idx_q     <= tx_idx_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
    end
  end

  assign tx              = tx_q;
  assign received        = received_q;
  assign recv_error      = recv_error_q;
  assign rx_byte         = rx_byte_q;
  assign is_receiving    = rx_state_q != RX_IDLE;
  assign is_transmitting = tx_state_q != TX_IDLE;

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed vector bench for the 8N1 UART at DIV=104
module tb_uart;
  localparam int DIV = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx, received, is_receiving, is_transmitting, recv_error;
  logic [7:0] rx_byte;

  uart #(.baud_rate(115200), .sys_clk_freq(12000000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .transmit(transmit), .tx_byte(tx_byte),
    .received(received), .rx_byte(rx_byte), .is_receiving(is_receiving),
    .is_transmitting(is_transmitting), .recv_error(recv_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_recv = 0;
  int n_err = 0;
  bit saw_busy;

  always @(posedge clk) begin
    if (received) n_recv <= n_recv + 1;
    if (recv_error) n_err <= n_err + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         recv;
    int         err;
    logic [7:0] exp_byte;
  } rx_vec_t;

  typedef struct {
    logic [7:0] data;
    int         second_at;
    logic [7:0] second;
  } tx_vec_t;

  rx_vec_t rv[6];
  tx_vec_t tv[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = f[b];
      repeat (DIV) begin
        tick();
        if (is_receiving) saw_busy = 1'b1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] d, input int second_at, input logic [7:0] d2);
    logic [9:0] f;
    int bad[10];
    int busy;
    int low;
    f = {1'b1, d, 1'b0};
    busy = 0;
    low = 0;
    for (int b = 0; b < 10; b++) bad[b] = 0;
    tx_byte = d;
    transmit = 1'b1;
    tick();
    for (int i = 0; i < 10 * DIV; i++) begin
      transmit = (i == second_at);
      if (i == second_at) tx_byte = d2;
      if (tx !== f[i / DIV]) bad[i / DIV]++;
      if (is_transmitting) busy++;
      tick();
    end
    transmit = 1'b0;
    for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_bad_cycles", b), bad[b], 0);
    check("tx_busy_cycles", busy, 10 * DIV);
    check("tx_idle_after", is_transmitting, 0);
    check("tx_high_after", tx, 1);
    for (int i = 0; i < 11 * DIV; i++) begin
      if (tx !== 1'b1 || is_transmitting) low++;
      tick();
    end
    check("tx_no_extra_frame", low, 0);
  endtask

  initial begin
    int r0, e0;
    logic [9:0] f;
    rv[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    rv[1] = '{8'h55, 1'b0, 0, 1, 8'hA5};
    rv[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    rv[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    rv[4] = '{8'h81, 1'b0, 0, 1, 8'hFF};
    rv[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    tv[0] = '{8'h3C, -1, 8'h00};
    tv[1] = '{8'hA5, 500, 8'hFF};

    repeat (3) tick();
    check("reset_tx", tx, 1);
    check("reset_received", received, 0);
    check("reset_recv_error", recv_error, 0);
    check("reset_is_receiving", is_receiving, 0);
    check("reset_is_transmitting", is_transmitting, 0);
    check("reset_rx_byte", rx_byte, 8'h00);
    rst = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 6; i++) begin
      r0 = n_recv;
      e0 = n_err;
      saw_busy = 1'b0;
      send_rx(rv[i].data, rv[i].stop);
      repeat (DIV) tick();
      check($sformatf("rx%0d_received_pulses", i), n_recv - r0, rv[i].recv);
      check($sformatf("rx%0d_error_pulses", i), n_err - e0, rv[i].err);
      check($sformatf("rx%0d_rx_byte", i), rx_byte, rv[i].exp_byte);
      check($sformatf("rx%0d_busy_seen", i), saw_busy, 1);
      check($sformatf("rx%0d_idle_after", i), is_receiving, 0);
    end

    r0 = n_recv;
    e0 = n_err;
    send_rx(8'h55, 1'b0);
    rx = 1'b0;
    repeat (12 * DIV) tick();
    check("break_still_waiting", is_receiving, 1);
    check("break_single_error", n_err - e0, 1);
    check("break_no_received", n_recv - r0, 0);
    check("break_rx_byte_kept", rx_byte, 8'h3C);
    rx = 1'b1;
    repeat (5) tick();
    check("break_rearmed", is_receiving, 0);

    r0 = n_recv;
    e0 = n_err;
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (10) tick();
    check("glitch_busy_mid", is_receiving, 1);
    repeat (30) tick();
    check("glitch_back_idle", is_receiving, 0);
    check("glitch_no_received", n_recv - r0, 0);
    check("glitch_no_error", n_err - e0, 0);

    for (int i = 0; i < 2; i++) send_tx(tv[i].data, tv[i].second_at, tv[i].second);

    tx_byte = 8'h01;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    repeat (10 * DIV - 1) tick();
    check("b2b_last_stop_cycle", is_transmitting, 1);
    tick();
    check("b2b_idle", is_transmitting, 0);
    transmit = 1'b1;
    tx_byte = 8'h02;
    tick();
    transmit = 1'b0;
    check("b2b_accepted_tx", tx, 0);
    check("b2b_accepted_busy", is_transmitting, 1);
    repeat (10 * DIV + 5) tick();

    r0 = n_recv;
    e0 = n_err;
    f = {1'b1, 8'hF0, 1'b0};
    tx_byte = 8'h3C;
    transmit = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx = f[i / DIV];
      tick();
      transmit = 1'b0;
    end
    check("mid_tx_busy", is_transmitting, 1);
    check("mid_rx_busy", is_receiving, 1);
    rst = 1'b0;
    #1;
    check("abort_tx_high", tx, 1);
    check("abort_is_transmitting", is_transmitting, 0);
    check("abort_is_receiving", is_receiving, 0);
    check("abort_received", received, 0);
    check("abort_recv_error", recv_error, 0);
    check("abort_rx_byte", rx_byte, 8'h00);
    rx = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("abort_no_received", n_recv - r0, 0);
    check("abort_no_error", n_err - e0, 0);
    check("abort_tx_stays_high", tx, 1);
    r0 = n_recv;
    send_rx(8'h81, 1'b1);
    repeat (DIV) tick();
    check("post_reset_rx_byte", rx_byte, 8'h81);
    check("post_reset_received", n_recv - r0, 1);
    check("post_reset_no_error", n_err - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter baud_rate, default 9600, line bit rate in bits/s.
REQ-002 Parameter sys_clk_freq, default 12000000, clk frequency in Hz.
REQ-003 Derived constant DIV = sys_clk_freq / baud_rate, integer-truncated; one bit period = DIV clk cycles; DIV >= 4 required.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-007 tx  output  1  serial transmit line, idle high.
REQ-008 transmit  input  1  single-cycle request to send tx_byte.
REQ-009 tx_byte  input  8  byte to send, sampled in the cycle transmit=1.
REQ-010 received  output  1  one-cycle pulse: valid byte on rx_byte.
REQ-011 rx_byte  output  8  last correctly received byte.
REQ-012 is_receiving  output  1  high while receiver not idle.
REQ-013 is_transmitting  output  1  high while transmitter not idle.
REQ-014 recv_error  output  1  one-cycle pulse on framing/stop-bit error.

Function
REQ-015 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-016 rx SHALL pass through a 2-flop synchronizer; all receiver decisions use the synchronized value (2-cycle input latency).
REQ-017 Receiver states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH.
REQ-018 RX_IDLE: on synchronized rx = 0, go to RX_START and load the bit timer with DIV/2.
REQ-019 RX_START: when the timer expires, if rx = 0 go to RX_DATA with timer = DIV and bit index 0; if rx = 1 treat as a glitch and return to RX_IDLE with no error and no pulse.
REQ-020 RX_DATA: each time the timer expires (every DIV cycles), shift rx into bit[index]; after bit 7, go to RX_STOP with timer = DIV.
REQ-021 RX_STOP on timer expiry: if rx = 1, update rx_byte, pulse received for exactly one cycle and go to RX_IDLE; if rx = 0, pulse recv_error for one cycle, leave rx_byte unchanged and go to RX_WAIT_HIGH.
REQ-022 RX_WAIT_HIGH SHALL stay until synchronized rx = 1, then go to RX_IDLE (no restart on a held-low break).
REQ-023 is_receiving SHALL equal (receiver state != RX_IDLE).
REQ-024 rx_byte SHALL hold its value between receptions.
REQ-025 Transmitter states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
REQ-026 TX_IDLE: on transmit = 1, latch tx_byte and enter TX_START; tx goes low on the next clk edge.
REQ-027 TX_START, each of the 8 TX_DATA bits (LSB first) and TX_STOP SHALL each drive tx for exactly DIV cycles; total frame = 10*DIV cycles.
REQ-028 After TX_STOP completes, return to TX_IDLE; is_transmitting falls in the same cycle, and a new transmit is accepted in that cycle.
REQ-029 transmit asserted while is_transmitting = 1 SHALL be ignored; the in-flight frame is unaffected and the request is not queued.
REQ-030 is_transmitting SHALL equal (transmitter state != TX_IDLE).
REQ-031 tx SHALL be registered (glitch-free).
REQ-032 Receiver and transmitter SHALL operate independently; full duplex, including loopback of tx to rx.

Reset
REQ-033 While rst = 0: tx = 1, received = 0, recv_error = 0, is_receiving = 0, is_transmitting = 0, rx_byte = 8'h00, both FSMs idle, timers and synchronizer flops cleared to the idle state (synchronizer = 1).
REQ-034 Reset asserted mid-frame SHALL abort both directions immediately; the partial byte is discarded with no pulses, and tx returns high asynchronously.

Verification (baud_rate=115200, sys_clk_freq=12000000, DIV=104)
REQ-035 Drive rx frame 0xA5 at 104 cycles/bit -> one received pulse, rx_byte = 8'hA5, recv_error never high, is_receiving high during the frame.
REQ-036 transmit=1 with tx_byte=0x3C -> tx shows 0,0,0,1,1,1,1,0,0,1, each bit 104 cycles; is_transmitting high for 1040 cycles.
REQ-037 rx frame 0x55 with stop bit = 0 -> one recv_error pulse, no received pulse, rx_byte keeps its previous value; receiver re-arms only after rx returns high.
REQ-038 rx low pulse of 20 cycles -> no received pulse, no recv_error, receiver back in RX_IDLE after DIV/2 cycles plus synchronizer latency.
REQ-039 Second transmit issued 500 cycles into a frame -> ignored; exactly one frame on tx.
REQ-040 rst pulled low 300 cycles into a tx frame and an rx frame -> tx = 1 immediately, all status outputs 0, no pulses; a subsequent 0x81 frame is received correctly.
